// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the memory request arbiter
package mem_arb_pkg;

    localparam int STREAK_WD = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOCK = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - IF/data winner selection with anti-starvation streak counter
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inst_valid_i,
    input  logic       data_valid_i,
    input  logic       accept_i,
    input  logic       accept_inst_i,
    output logic [1:0] winner_o
);

    localparam logic [STREAK_WD-1:0] LIMIT = STREAK_WD'(STARVE_LIMIT);

    logic [STREAK_WD-1:0] streak_q, streak_d;

    always_comb begin
        winner_o = NONE;
        if (inst_valid_i && data_valid_i) begin
            winner_o = (streak_q == LIMIT) ? INST : DATA;
        end else if (data_valid_i) begin
            winner_o = DATA;
        end else if (inst_valid_i) begin
            winner_o = INST;
        end
    end

    // Streak only grows while IF is actually waiting behind a data grant.
    always_comb begin
        streak_d = streak_q;
        if (accept_i) begin
            if (accept_inst_i || !inst_valid_i) begin
                streak_d = '0;
            end else if (streak_q < LIMIT) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - shares one cache request port between IF and data requesters
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Inst_Req_Valid,
    input  logic [31:0] PC,
    output logic        Inst_Req_Ready,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ready,
    input  logic [31:0] Address,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready,
    output logic [31:0] m_Address,
    output logic        m_MemRead,
    output logic        m_MemWrite,
    output logic [31:0] m_Write_data,
    output logic [3:0]  m_Write_strb,
    input  logic        m_Req_Ready,
    input  logic [31:0] m_Read_data,
    input  logic        m_Read_data_Valid,
    output logic        m_Read_data_Ready
);

    state_t     state_q, state_d;
    owner_t     owner_q, owner_d;
    owner_t     grant;
    owner_t     winner;
    logic [1:0] winner_raw;
    logic       data_valid;
    logic       accept;

    assign data_valid = MemRead | MemWrite;
    assign winner     = owner_t'(winner_raw);

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk           (clk),
        .rst           (rst),
        .inst_valid_i  (Inst_Req_Valid),
        .data_valid_i  (data_valid),
        .accept_i      (accept),
        .accept_inst_i (grant == INST),
        .winner_o      (winner_raw)
    );

    // rst gates the grant so the request side goes quiet the moment reset rises.
    always_comb begin
        grant = NONE;
        if (!rst) begin
            case (state_q)
                IDLE:    grant = winner;
                LOCK:    grant = owner_q;
                default: grant = NONE;
            endcase
        end
    end

    always_comb begin
        m_Address    = '0;
        m_MemRead    = 1'b0;
        m_MemWrite   = 1'b0;
        m_Write_data = '0;
        m_Write_strb = '0;
        if (grant == INST) begin
            m_Address = PC;
            m_MemRead = 1'b1;
        end else if (grant == DATA) begin
            m_Address    = Address;
            m_MemRead    = MemRead & ~MemWrite;
            m_MemWrite   = MemWrite;
            m_Write_data = Write_data;
            m_Write_strb = Write_strb;
        end
    end

    assign accept         = m_Req_Ready && (grant != NONE);
    assign Inst_Req_Ready = m_Req_Ready && (grant == INST);
    assign Mem_Req_Ready  = m_Req_Ready && (grant == DATA);

    always_comb begin
        Instruction       = '0;
        Inst_Valid        = 1'b0;
        Read_data         = '0;
        Read_data_Valid   = 1'b0;
        m_Read_data_Ready = 1'b0;
        if (state_q == RESP) begin
            if (owner_q == INST) begin
                Instruction       = m_Read_data;
                Inst_Valid        = m_Read_data_Valid;
                m_Read_data_Ready = Inst_Ready;
            end else if (owner_q == DATA) begin
                Read_data         = m_Read_data;
                Read_data_Valid   = m_Read_data_Valid;
                m_Read_data_Ready = Read_data_Ready;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            IDLE, LOCK: begin
                if (grant != NONE) begin
                    if (accept) begin
                        state_d = m_MemRead ? RESP : IDLE;
                        owner_d = m_MemRead ? grant : NONE;
                    end else begin
                        state_d = LOCK;
                        owner_d = grant;
                    end
                end
            end
            RESP: begin
                if (m_Read_data_Valid && m_Read_data_Ready) begin
                    state_d = IDLE;
                    owner_d = NONE;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    a_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(MemRead && MemWrite))
        else $error("MemRead and MemWrite asserted together");

    a_lock_inst_held: assert property (@(posedge clk) disable iff (rst)
        (state_q == LOCK && owner_q == INST) |-> Inst_Req_Valid)
        else $error("IF request dropped while locked");

    a_lock_data_held: assert property (@(posedge clk) disable iff (rst)
        (state_q == LOCK && owner_q == DATA) |-> data_valid)
        else $error("data request dropped while locked");

endmodule
